rom_port_arbiter: RTL and testbench

//  Shares one toggle-handshake SDRAM port between the main CPU ROM fetch, the sound CPU ROM

---
 rtl/rom_port_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// ============================================================================
// Module   : rom_port_arbiter
// Brief    : Shares one toggle-handshake SDRAM port between CPU ROM, sound ROM
//            and the ROM download writer, with a one-word cache per CPU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_port_arbiter #(
    parameter logic [22:0] CPU_BASE = 23'h000000,
    parameter logic [22:0] SND_BASE = 23'h007000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_dout,
    output logic        cpu_rdy,
    input  logic [13:0] snd_addr,
    input  logic        snd_rd,
    output logic [7:0]  snd_dout,
    output logic        snd_rdy,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_busy,
    output logic        dl_overrun,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [22:0] mem_a,
    output logic [1:0]  mem_ds,
    output logic [15:0] mem_d,
    input  logic [15:0] mem_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        G_CPU = 2'd0,
        G_SND = 2'd1,
        G_DL  = 2'd2
    } grant_t;

    state_t      r_state, w_state_nxt;
    grant_t      r_grant, w_grant_nxt;
    logic        r_rr;
    logic        r_cpu_pend, r_cpu_lsb, r_snd_pend, r_snd_lsb;
    logic [22:0] r_cpu_word, r_snd_word;
    logic        r_cpu_cv, r_snd_cv;
    logic [22:0] r_cpu_tag, r_snd_tag;
    logic [15:0] r_cpu_cdata, r_snd_cdata;
    logic [22:0] r_dl_a;
    logic [1:0]  r_dl_ds;
    logic [15:0] r_dl_d;
    logic        r_dl_seen;
    logic [15:0] r_rd_data;

    logic [22:0] w_cpu_word, w_snd_word;
    logic        w_dl_accept, w_cpu_hit, w_snd_hit, w_ack_match;
    logic        w_unused;

    assign w_cpu_word  = CPU_BASE + {8'd0, cpu_addr[15:1]};
    assign w_snd_word  = SND_BASE + {10'd0, snd_addr[13:1]};
    assign w_dl_accept = dl_wr & ~dl_busy;
    assign w_ack_match = (mem_ack == mem_req);
    assign w_unused    = dl_addr[24];

    // A hit is resolved at capture so the byte appears one cycle after the strobe;
    // a download accepted in the same cycle invalidates the entry, so it loses.
    assign w_cpu_hit = cpu_rd & ~r_cpu_pend & r_cpu_cv & (r_cpu_tag == w_cpu_word) & ~w_dl_accept;
    assign w_snd_hit = snd_rd & ~r_snd_pend & r_snd_cv & (r_snd_tag == w_snd_word) & ~w_dl_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            S_IDLE: begin
                if (dl_busy || r_cpu_pend || r_snd_pend) begin
                    w_state_nxt = S_ISSUE;
                    if (dl_busy)
                        w_grant_nxt = G_DL;
                    else if (!r_rr)
                        w_grant_nxt = r_cpu_pend ? G_CPU : G_SND;
                    else
                        w_grant_nxt = r_snd_pend ? G_SND : G_CPU;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_ack_match) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= G_CPU;
            r_rr        <= 1'b0;
            r_cpu_pend  <= 1'b0;
            r_cpu_lsb   <= 1'b0;
            r_cpu_word  <= '0;
            r_snd_pend  <= 1'b0;
            r_snd_lsb   <= 1'b0;
            r_snd_word  <= '0;
            r_cpu_cv    <= 1'b0;
            r_cpu_tag   <= '0;
            r_cpu_cdata <= '0;
            r_snd_cv    <= 1'b0;
            r_snd_tag   <= '0;
            r_snd_cdata <= '0;
            r_dl_a      <= '0;
            r_dl_ds     <= '0;
            r_dl_d      <= '0;
            r_dl_seen   <= 1'b0;
            r_rd_data   <= '0;
            cpu_dout    <= '0;
            cpu_rdy     <= 1'b0;
            snd_dout    <= '0;
            snd_rdy     <= 1'b0;
            dl_busy     <= 1'b0;
            dl_overrun  <= 1'b0;
            mem_req     <= mem_ack;
            mem_we      <= 1'b0;
            mem_a       <= '0;
            mem_ds      <= '0;
            mem_d       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            cpu_rdy <= 1'b0;
            snd_rdy <= 1'b0;

            if (cpu_rd && !r_cpu_pend) begin
                if (w_cpu_hit) begin
                    cpu_rdy  <= 1'b1;
                    cpu_dout <= cpu_addr[0] ? r_cpu_cdata[15:8] : r_cpu_cdata[7:0];
                end else begin
                    r_cpu_pend <= 1'b1;
                    r_cpu_word <= w_cpu_word;
                    r_cpu_lsb  <= cpu_addr[0];
                end
            end
            if (snd_rd && !r_snd_pend) begin
                if (w_snd_hit) begin
                    snd_rdy  <= 1'b1;
                    snd_dout <= snd_addr[0] ? r_snd_cdata[15:8] : r_snd_cdata[7:0];
                end else begin
                    r_snd_pend <= 1'b1;
                    r_snd_word <= w_snd_word;
                    r_snd_lsb  <= snd_addr[0];
                end
            end

            // Remembers a download landing mid-read so stale data is never cached.
            if (r_state == S_ISSUE)
                r_dl_seen <= w_dl_accept;
            else if (w_dl_accept)
                r_dl_seen <= 1'b1;

            case (r_state)
                S_ISSUE: begin
                    mem_req <= ~mem_req;
                    case (r_grant)
                        G_DL: begin
                            mem_we <= 1'b1;
                            mem_a  <= r_dl_a;
                            mem_ds <= r_dl_ds;
                            mem_d  <= r_dl_d;
                        end
                        G_CPU: begin
                            mem_we <= 1'b0;
                            mem_a  <= r_cpu_word;
                            mem_ds <= 2'b11;
                        end
                        default: begin
                            mem_we <= 1'b0;
                            mem_a  <= r_snd_word;
                            mem_ds <= 2'b11;
                        end
                    endcase
                end
                S_WAIT: begin
                    if (w_ack_match) begin
                        if (r_grant == G_DL) begin
                            dl_busy <= 1'b0;
                        end else begin
                            r_rd_data <= mem_q;
                            if (!r_dl_seen && !w_dl_accept) begin
                                if (r_grant == G_CPU) begin
                                    r_cpu_cv    <= 1'b1;
                                    r_cpu_tag   <= r_cpu_word;
                                    r_cpu_cdata <= mem_q;
                                end else begin
                                    r_snd_cv    <= 1'b1;
                                    r_snd_tag   <= r_snd_word;
                                    r_snd_cdata <= mem_q;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (r_grant == G_CPU) begin
                        cpu_rdy    <= 1'b1;
                        cpu_dout   <= r_cpu_lsb ? r_rd_data[15:8] : r_rd_data[7:0];
                        r_cpu_pend <= 1'b0;
                        r_rr       <= 1'b1;
                    end else if (r_grant == G_SND) begin
                        snd_rdy    <= 1'b1;
                        snd_dout   <= r_snd_lsb ? r_rd_data[15:8] : r_rd_data[7:0];
                        r_snd_pend <= 1'b0;
                        r_rr       <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (w_dl_accept) begin
                dl_busy  <= 1'b1;
                r_dl_a   <= dl_addr[23:1];
                r_dl_ds  <= {dl_addr[0], ~dl_addr[0]};
                r_dl_d   <= {dl_data, dl_data};
                r_cpu_cv <= 1'b0;
                r_snd_cv <= 1'b0;
            end else if (dl_wr) begin
                dl_overrun <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
// ============================================================================
// Module   : tb_rom_port_arbiter
// Brief    : Scoreboard bench for rom_port_arbiter with a toggle-handshake SDRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_port_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rd = 1'b0;
    logic [7:0]  cpu_dout;
    logic        cpu_rdy;
    logic [13:0] snd_addr = '0;
    logic        snd_rd = 1'b0;
    logic [7:0]  snd_dout;
    logic        snd_rdy;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        dl_busy;
    logic        dl_overrun;
    logic        mem_req;
    logic        mem_ack = 1'b1;
    logic        mem_we;
    logic [22:0] mem_a;
    logic [1:0]  mem_ds;
    logic [15:0] mem_d;
    logic [15:0] mem_q = '0;

    always #5 clk_sys = ~clk_sys;

    rom_port_arbiter #(.CPU_BASE(23'h000000), .SND_BASE(23'h007000)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy),
        .snd_addr(snd_addr), .snd_rd(snd_rd), .snd_dout(snd_dout), .snd_rdy(snd_rdy),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_busy(dl_busy), .dl_overrun(dl_overrun),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_a(mem_a),
        .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard entries are {requester (0=cpu,1=snd), byte}.
    logic [8:0] sb[$];

    always @(negedge clk_sys) begin
        if (cpu_rdy) begin
            if (sb.size() == 0) check("cpu_rdy_unexpected", {23'd0, 1'b0, cpu_dout}, 32'h1FF);
            else check("cpu_rdy_data", {23'd0, 1'b0, cpu_dout}, {23'd0, sb.pop_front()});
        end
        if (snd_rdy) begin
            if (sb.size() == 0) check("snd_rdy_unexpected", {23'd0, 1'b1, snd_dout}, 32'h0FF);
            else check("snd_rdy_data", {23'd0, 1'b1, snd_dout}, {23'd0, sb.pop_front()});
        end
    end

    // SDRAM model: completes each access resp_delay cycles after seeing the toggle.
    logic [15:0] mem [logic [22:0]];
    int          resp_delay = 4;
    int          resp_cnt = 0;
    bit          resp_busy = 1'b0;
    bit          stable = 1'b1;
    bit          rst_seen = 1'b0;
    int          acc_cnt = 0;
    logic [22:0] la = '0;
    logic        lwe = 1'b0;
    logic [1:0]  lds = '0;
    logic [15:0] ld = '0;
    logic [15:0] wtmp;
    logic [22:0] acc_log[$];

    always @(negedge clk_sys) begin
        if (resp_busy) begin
            if (!reset && (mem_a !== la || mem_we !== lwe || mem_ds !== lds || mem_d !== ld))
                stable = 1'b0;
            if (resp_cnt <= 1) begin
                if (lwe) begin
                    wtmp = mem.exists(la) ? mem[la] : 16'h0000;
                    if (lds[1]) wtmp[15:8] = ld[15:8];
                    if (lds[0]) wtmp[7:0]  = ld[7:0];
                    mem[la] = wtmp;
                end else begin
                    mem_q = mem.exists(la) ? mem[la] : 16'h0000;
                end
                mem_ack   = ~mem_ack;
                resp_busy = 1'b0;
                if (!rst_seen) check("mem_stable", {31'd0, stable}, 32'd1);
            end else begin
                resp_cnt--;
            end
        end else if (!reset && mem_req !== mem_ack) begin
            resp_busy = 1'b1;
            resp_cnt  = resp_delay;
            la = mem_a; lwe = mem_we; lds = mem_ds; ld = mem_d;
            stable   = 1'b1;
            rst_seen = 1'b0;
            acc_cnt++;
            acc_log.push_back(mem_a);
        end
        if (reset) rst_seen = 1'b1;
    end

    task automatic cpu_req(input logic [15:0] a);
        @(negedge clk_sys);
        cpu_addr = a; cpu_rd = 1'b1;
        @(negedge clk_sys);
        cpu_rd = 1'b0;
    endtask

    task automatic snd_req(input logic [13:0] a);
        @(negedge clk_sys);
        snd_addr = a; snd_rd = 1'b1;
        @(negedge clk_sys);
        snd_rd = 1'b0;
    endtask

    task automatic both_req(input logic [15:0] ca, input logic [13:0] sa);
        @(negedge clk_sys);
        cpu_addr = ca; cpu_rd = 1'b1;
        snd_addr = sa; snd_rd = 1'b1;
        @(negedge clk_sys);
        cpu_rd = 1'b0; snd_rd = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !resp_busy && !dl_busy) break;
            @(negedge clk_sys);
        end
        check(name, sb.size(), 0);
        repeat (3) @(negedge clk_sys);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int l0;
        logic r0;

        mem[23'h000001] = 16'hA55A;
        mem[23'h007008] = 16'h1234;
        mem[23'h000080] = 16'hBEEF;
        mem[23'h007010] = 16'hC0DE;
        mem[23'h000100] = 16'h7788;
        mem[23'h000180] = 16'h1122;
        mem[23'h007020] = 16'h3344;
        mem[23'h000200] = 16'h5566;

        // Reset with mem_ack high
        repeat (5) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_mem_req", {31'd0, mem_req}, 32'd1);
        check("rst_rdy", {30'd0, cpu_rdy, snd_rdy}, 32'd0);
        check("rst_dout", {16'd0, cpu_dout, snd_dout}, 32'd0);
        check("rst_dl", {30'd0, dl_busy, dl_overrun}, 32'd0);
        check("rst_mem_a", {9'd0, mem_a}, 32'd0);
        check("rst_mem_ctl", {13'd0, mem_we, mem_ds, mem_d}, 32'd0);
        repeat (10) @(negedge clk_sys);
        check("rst_no_access", acc_cnt, 0);
        check("rst_req_idle", {31'd0, mem_req}, 32'd1);

        // CPU miss, odd byte
        sb.push_back({1'b0, 8'hA5});
        cpu_req(16'h0003);
        drain("cpu_miss_drain");
        check("cpu_miss_a", {9'd0, la}, 32'h000001);
        check("cpu_miss_we", {31'd0, lwe}, 32'd0);
        check("cpu_miss_acc", acc_cnt, 1);

        // CPU hit, latency 1, no SDRAM access
        a0 = acc_cnt; r0 = mem_req;
        sb.push_back({1'b0, 8'h5A});
        cpu_req(16'h0002);
        check("cpu_hit_latency", {31'd0, cpu_rdy}, 32'd1);
        drain("cpu_hit_drain");
        check("cpu_hit_no_acc", acc_cnt, a0);
        check("cpu_hit_req", {31'd0, mem_req}, {31'd0, r0});

        // Sound miss
        sb.push_back({1'b1, 8'h34});
        snd_req(14'h0010);
        drain("snd_miss_drain");
        check("snd_miss_a", {9'd0, la}, 32'h007008);

        // Contention with rr pointing at CPU
        l0 = acc_log.size();
        sb.push_back({1'b0, 8'hEF});
        sb.push_back({1'b1, 8'hC0});
        both_req(16'h0100, 14'h0021);
        drain("cont1_drain");
        check("cont1_first", {9'd0, acc_log[l0]}, 32'h000080);
        check("cont1_second", {9'd0, acc_log[l0+1]}, 32'h007010);

        // A CPU-only miss leaves rr pointing at sound
        sb.push_back({1'b0, 8'h88});
        cpu_req(16'h0200);
        drain("cpu_only_drain");

        // Contention with rr pointing at sound
        l0 = acc_log.size();
        sb.push_back({1'b1, 8'h33});
        sb.push_back({1'b0, 8'h11});
        both_req(16'h0301, 14'h0041);
        drain("cont2_drain");
        check("cont2_first", {9'd0, acc_log[l0]}, 32'h007020);
        check("cont2_second", {9'd0, acc_log[l0+1]}, 32'h000180);

        // CPU word 0x180 is now cached
        a0 = acc_cnt;
        sb.push_back({1'b0, 8'h22});
        cpu_req(16'h0300);
        drain("cpu_hit2_drain");
        check("cpu_hit2_no_acc", acc_cnt, a0);

        // Download write, then overrun while busy
        @(negedge clk_sys);
        dl_addr = 25'h0012001; dl_data = 8'h3C; dl_wr = 1'b1;
        @(negedge clk_sys);
        check("dl_busy_set", {31'd0, dl_busy}, 32'd1);
        dl_data = 8'h99;
        @(negedge clk_sys);
        dl_wr = 1'b0;
        check("dl_overrun_set", {31'd0, dl_overrun}, 32'd1);
        drain("dl_drain");
        check("dl_we", {31'd0, lwe}, 32'd1);
        check("dl_a", {9'd0, la}, 32'h009000);
        check("dl_ds", {30'd0, lds}, 32'd2);
        check("dl_d", {16'd0, ld}, 32'h3C3C);
        check("dl_mem_word", {16'd0, mem[23'h009000]}, 32'h3C00);
        check("dl_overrun_sticky", {31'd0, dl_overrun}, 32'd1);

        // Both caches were invalidated
        a0 = acc_cnt;
        sb.push_back({1'b0, 8'h22});
        cpu_req(16'h0300);
        drain("inval_cpu_drain");
        check("inval_cpu_acc", acc_cnt, a0 + 1);
        a0 = acc_cnt;
        sb.push_back({1'b1, 8'h33});
        snd_req(14'h0041);
        drain("inval_snd_drain");
        check("inval_snd_acc", acc_cnt, a0 + 1);

        // Reset during WAIT; the ack lands while reset is held
        cpu_req(16'h0400);
        for (int i = 0; i < 20; i++) begin
            if (resp_busy) break;
            @(negedge clk_sys);
        end
        check("wait_reached", {31'd0, resp_busy}, 32'd1);
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (6) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_wait_req_ack", {31'd0, mem_req}, {31'd0, mem_ack});
        check("rst_wait_resp_idle", {31'd0, resp_busy}, 32'd0);
        a0 = acc_cnt;
        repeat (10) @(negedge clk_sys);
        check("rst_wait_no_phantom", acc_cnt, a0);
        check("rst_wait_no_rdy", sb.size(), 0);

        sb.push_back({1'b0, 8'h66});
        cpu_req(16'h0400);
        drain("post_rst_drain");
        check("post_rst_acc", acc_cnt, a0 + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
